// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_seq_pkg : shared types and constants for the PC sequencer     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pc_seq_pkg;

  localparam int PC_W    = 32;
  localparam int PC_INCR = 4;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } pc_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : enabled up-counter, sync active-low clear, sticks  |
// | at all-ones.  Rev 1.0                                            |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             clear_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_sequencer : chooses PC+4 / branch target / hold each cycle,   |
// | buffers redirects resolved during a stall. Rev 1.0               |
// +------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   imem_busywait,
  input  logic                   dmem_busywait,
  input  logic                   branch_req,
  input  logic [PC_W-1:0]        branch_target,
  output logic                   pc_en,
  output logic                   pc_sel,
  output logic [PC_W-1:0]        pc_target,
  output logic                   flush,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [7:0] c_hold_init = 8'(RESET_HOLD_CYCLES - 1);

  pc_state_t       r_state;
  logic            r_pending;
  logic [PC_W-1:0] r_pend_target;
  logic [7:0]      r_hold_cnt;
  logic            w_busy;

  assign w_busy = imem_busywait | dmem_busywait;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state       <= HOLD;
      r_pending     <= 1'b0;
      r_pend_target <= '0;
      r_hold_cnt    <= c_hold_init;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == 8'd0) r_state <= RUN;
          else                    r_hold_cnt <= r_hold_cnt - 8'd1;
        end
        RUN: begin
          if (w_busy) begin
            r_state <= STALL;
            if (branch_req) begin
              r_pending     <= 1'b1;
              r_pend_target <= branch_target;
            end
          end
        end
        STALL: begin
          if (w_busy) begin
            // first redirect captured during a stall wins
            if (branch_req && !r_pending) begin
              r_pending     <= 1'b1;
              r_pend_target <= branch_target;
            end
          end else begin
            r_pending <= 1'b0;
            r_state   <= RUN;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  always_comb begin
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    pc_target = branch_target;
    flush     = 1'b0;
    stall     = 1'b1;
    if (!RESET) begin
      pc_target = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_busy) begin
            pc_en  = 1'b1;
            pc_sel = branch_req;
            flush  = branch_req;
            stall  = 1'b0;
          end
        end
        STALL: begin
          if (!w_busy) begin
            pc_en = 1'b1;
            stall = 1'b0;
            if (r_pending) begin
              pc_sel    = 1'b1;
              pc_target = r_pend_target;
              flush     = 1'b1;
            end else begin
              pc_sel = branch_req;
              flush  = branch_req;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .CLK     (CLK),
    .clear_n (RESET),
    .en      (stall),
    .count   (stall_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_sequencer : scoreboard bench for pc_sequencer              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        imem_busywait, dmem_busywait, branch_req;
  logic [31:0] branch_target;
  logic        pc_en, pc_sel, flush, stall;
  logic [31:0] pc_target;
  logic [15:0] stall_count;
  logic        s_pc_en, s_pc_sel, s_flush, s_stall;
  logic [31:0] s_pc_target;
  logic [2:0]  s_stall_count;

  typedef struct {
    logic        en;
    logic        sel;
    logic [31:0] tgt;
    logic        fl;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  bit   cnt_known = 1'b0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.RESET_HOLD_CYCLES(4), .STALL_CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .branch_req(branch_req), .branch_target(branch_target), .pc_en(pc_en), .pc_sel(pc_sel),
    .pc_target(pc_target), .flush(flush), .stall(stall), .stall_count(stall_count)
  );

  pc_sequencer #(.RESET_HOLD_CYCLES(4), .STALL_CNT_W(3)) dut_sat (
    .CLK(CLK), .RESET(RESET), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .branch_req(branch_req), .branch_target(branch_target), .pc_en(s_pc_en), .pc_sel(s_pc_sel),
    .pc_target(s_pc_target), .flush(s_flush), .stall(s_stall), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // drive one cycle, queue what the outputs must be, then score before the edge
  task automatic step(input logic rst, input logic im, input logic dm, input logic br,
                      input logic [31:0] tg, input logic en, input logic sel,
                      input logic [31:0] et, input logic fl, input logic st);
    exp_t e;
    RESET = rst; imem_busywait = im; dmem_busywait = dm;
    branch_req = br; branch_target = tg;
    e = '{en: en, sel: sel, tgt: et, fl: fl, st: st};
    q.push_back(e);
    #2;
    e = q.pop_front();
    chk("pc_en",     32'(pc_en),  32'(e.en));
    chk("pc_sel",    32'(pc_sel), 32'(e.sel));
    chk("pc_target", pc_target,   e.tgt);
    chk("flush",     32'(flush),  32'(e.fl));
    chk("stall",     32'(stall),  32'(e.st));
    if (cnt_known) begin
      chk("stall_count", 32'(stall_count),   32'(exp_cnt));
      chk("sat_count",   32'(s_stall_count), (exp_cnt > 7) ? 32'd7 : 32'(exp_cnt));
    end
    @(posedge CLK);
    if (!rst) begin
      exp_cnt   = 0;
      cnt_known = 1'b1;
    end else if (st && exp_cnt < 65535) begin
      exp_cnt++;
    end
    @(negedge CLK);
  endtask

  task automatic rst_cyc(input logic busy, input logic br, input logic [31:0] tg);
    step(1'b0, busy, 1'b0, br, tg, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic hold_cyc(input logic br, input logic [31:0] tg);
    step(1'b1, 1'b0, 1'b0, br, tg, 1'b0, 1'b0, tg, 1'b0, 1'b1);
  endtask

  task automatic busy_cyc(input logic im, input logic dm, input logic br, input logic [31:0] tg);
    step(1'b1, im, dm, br, tg, 1'b0, 1'b0, tg, 1'b0, 1'b1);
  endtask

  task automatic go_cyc(input logic br, input logic [31:0] tg,
                        input logic sel, input logic [31:0] et);
    step(1'b1, 1'b0, 1'b0, br, tg, 1'b1, sel, et, sel, 1'b0);
  endtask

  initial begin
    RESET = 1'b0; imem_busywait = 1'b0; dmem_busywait = 1'b0;
    branch_req = 1'b0; branch_target = 32'h0;
    @(negedge CLK);

    // reset forces outputs even with a live branch
    rst_cyc(1'b0, 1'b1, 32'h55);
    rst_cyc(1'b0, 1'b1, 32'h55);

    // hold window: exactly four cycles, branches ignored
    hold_cyc(1'b0, 32'h0);
    hold_cyc(1'b1, 32'h99);
    hold_cyc(1'b0, 32'h0);
    hold_cyc(1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);

    // zero-latency redirect in RUN
    go_cyc(1'b1, 32'h40, 1'b1, 32'h40);

    // imem stall, first captured target wins
    busy_cyc(1'b1, 1'b0, 1'b1, 32'h100);
    busy_cyc(1'b1, 1'b0, 1'b1, 32'h200);
    busy_cyc(1'b1, 1'b0, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b1, 32'h100);

    // dmem stall without branch
    busy_cyc(1'b0, 1'b1, 1'b0, 32'h0);
    busy_cyc(1'b0, 1'b1, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);

    // pending beats a live branch on busy release
    busy_cyc(1'b1, 1'b1, 1'b1, 32'h300);
    go_cyc(1'b1, 32'h400, 1'b1, 32'h300);

    // no pending: live branch taken on busy release
    busy_cyc(1'b0, 1'b1, 1'b0, 32'h0);
    go_cyc(1'b1, 32'h500, 1'b1, 32'h500);

    // busy toggling every cycle
    busy_cyc(1'b1, 1'b0, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);
    busy_cyc(1'b0, 1'b1, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);

    // reset mid-stall drops the pending redirect
    busy_cyc(1'b1, 1'b0, 1'b1, 32'h80);
    busy_cyc(1'b1, 1'b0, 1'b0, 32'h0);
    rst_cyc(1'b1, 1'b0, 32'h0);
    hold_cyc(1'b0, 32'h0);
    hold_cyc(1'b0, 32'h0);
    hold_cyc(1'b0, 32'h0);
    hold_cyc(1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);

    // long stall drives the narrow counter into saturation
    for (int i = 0; i < 10; i++) busy_cyc(1'b1, 1'b0, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);
    go_cyc(1'b0, 32'h0, 1'b0, 32'h0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the program counter register: it decides each cycle whether the PC advances to PC+4, loads a branch target, or holds. It sits between the datapath's branch-resolution logic and the PC register, merging instruction- and data-memory busywait into a single stall. It also buffers a branch redirect that resolves during a stall, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- RESET_HOLD_CYCLES, 4, cycles PC is held after reset release (legal range 1..255).
- STALL_CNT_W, 16, width of saturating stall counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-low reset (0 = reset).
- imem_busywait  input  1  instruction memory/cache not ready.
- dmem_busywait  input  1  data memory/cache not ready.
- branch_req  input  1  taken branch/jump resolved this cycle.
- branch_target  input  32  absolute target address valid with branch_req.
- pc_en  output  1  PC register loads at next posedge.
- pc_sel  output  1  0 = load PC+4, 1 = load pc_target.
- pc_target  output  32  target address for PC load when pc_sel = 1.
- flush  output  1  kill in-flight fetched instruction (redirect taken).
- stall  output  1  pipeline frozen this cycle.
- stall_count  output  STALL_CNT_W  saturating count of stall cycles since reset.

## Operation
- busy = imem_busywait | dmem_busywait.
- States: HOLD, RUN, STALL. Extra state: pending flag, pend_target[31:0], hold counter (8 bit).
- HOLD: pc_en=0, stall=1, flush=0. Counter loads RESET_HOLD_CYCLES-1 on reset and decrements; at 0, next state RUN. branch_req ignored.
- RUN, busy=0: pc_en=1, pc_sel=branch_req, pc_target=branch_target, flush=branch_req, stall=0. Stay RUN.
- RUN, busy=1: pc_en=0, stall=1, flush=0. Next STALL; if branch_req, pending<=1, pend_target<=branch_target.
- STALL, busy=1: pc_en=0, stall=1. If branch_req and !pending, capture as above. If pending already set, new branch_req ignored; first capture wins.
- STALL, busy=0: pc_en=1, stall=0. If pending: pc_sel=1, pc_target=pend_target, flush=1. Else pc_sel=branch_req, pc_target=branch_target, flush=branch_req. Clear pending; next RUN.
- When pc_sel=0, pc_target=branch_target (don't-care for PC, but defined).
- stall_count increments each cycle stall=1 while RESET=1. It saturates at 2^STALL_CNT_W-1 and never wraps.

## Timing
- Outputs pc_en, pc_sel, pc_target, flush, stall are combinational from state and current inputs (Mealy). The PC register samples them at the same posedge.
- Redirect latency: 0 cycles in RUN; busy-low cycle in STALL.
- Reset (RESET=0 sampled at posedge), in any state: next state HOLD, pending=0, pend_target=0, stall_count=0, hold counter reloaded.
- While RESET=0, outputs are forced: pc_en=0, flush=0, stall=1, pc_sel=0, pc_target=0.
- Reset mid-stall discards any pending redirect.
- After RESET rises: exactly RESET_HOLD_CYCLES cycles with pc_en=0, then first pc_en=1 cycle (if not busy).
- Simultaneous busy deassert and branch_req with pending set: pending target used; live branch_req dropped.
- Busy may toggle every cycle; each busy=1 cycle is counted as a stall.

## Structure
- Package pc_seq_pkg: state enum (HOLD, RUN, STALL), PC_INCR constant (4), PC_W constant (32).
- Sub-module sat_counter: parameterised width, enable, synchronous active-low clear, saturating at all-ones. Instantiated for stall_count.
- Top: state register, pending/pend_target registers, hold counter, combinational output logic.

## Test plan
- Reset release, RESET_HOLD_CYCLES=4, busy=0 -> pc_en=0 for 4 cycles, then pc_en=1, pc_sel=0 every cycle; stall_count=4.
- RUN, branch_req=1, target 0x0000_0040, busy=0 -> same cycle pc_en=1, pc_sel=1, pc_target=0x40, flush=1.
- RUN, imem_busywait high 3 cycles with branch_req=1, target 0x100 in first cycle, then 0x200 in second cycle -> pc_en=0 for 3 cycles. On busy drop: pc_sel=1, pc_target=0x100, flush=1; stall_count increases by 3.
- dmem_busywait high 2 cycles, no branch -> pc_en=0 two cycles, then pc_en=1, pc_sel=0, flush=0.
- Pending redirect 0x80 captured, RESET=0 while stalled -> pending cleared; after reset and hold, first load is pc_sel=0, stall_count restarted from 0.
- STALL_CNT_W=3, busy held 10 cycles -> stall_count reaches 7 and stays at 7.
